key_event_tx: RTL
=================

// Module: key_event_tx
// PURPOSE
// Consumes the one-cycle key event pulses from the debounced key scanner and turns each
// into a 4-byte ASCII report "K<n>\r\n" for the UART transmitter, e.g. "K3\r\n" for S3.
// A small event FIFO absorbs bursts of presses while the UART is busy.
// Sits between the key scanner and the UART TX byte interface (valid/ready).
// PARAMETERS
// FIFO_DEPTH  4      event queue depth; power of 2, >= 2
// PREFIX      8'h4B  first byte of every report ('K')
// PORTS
// key_clk    in   1  system clock; all logic on rising edge
// key_rst    in   1  synchronous reset, active low
// key_value  in   4  key event: 4'b1111 = none; 0001/0010/0100/1000 = S1..S4, 1-cycle pulse
// tx_ready   in   1  UART TX can accept tx_data this cycle
// tx_data    out  8  byte offered to UART TX
// tx_valid   out  1  tx_data is valid; transfer occurs when tx_valid && tx_ready at an edge
// busy       out  1  high while a report is being sent or the FIFO is non-empty
// evt_drop   out  1  1-cycle pulse: event lost because FIFO was full
// evt_cnt    out  8  count of accepted events, wraps 255 -> 0
// BEHAVIOUR
// - Reset (key_rst low at edge): FIFO empty, state IDLE, tx_data=0, tx_valid=0,
//   busy=0, evt_drop=0, evt_cnt=0. Reset mid-report aborts it; no partial bytes after.
// - Event decode: only the four one-hot codes are events, coded 2-bit index 0..3 (S1..S4).
//   1111 and any other pattern (0000, 0011, ...) ignored; held codes count once per cycle.
// - Push: event and FIFO not full -> written at that edge, evt_cnt += 1.
//   Event and FIFO full -> not written, evt_drop high next cycle, evt_cnt unchanged.
//   Fullness is judged before any same-cycle pop: event while full is dropped even if a
//   pop occurs that cycle.
// - FSM states: IDLE, SEND.
//   IDLE: FIFO non-empty -> pop head, latch index, byte_idx=0, tx_valid=1 next cycle -> SEND.
//   SEND: tx_data by byte_idx: 0=PREFIX, 1=8'h31+index, 2=8'h0D, 3=8'h0A.
//     tx_valid && tx_ready: byte_idx 0..2 -> byte_idx+1, next byte offered next cycle;
//     byte_idx 3 -> tx_valid=0, go IDLE.
//     !tx_ready: tx_data and tx_valid held unchanged (no retraction, no change while valid).
// - Latency: event at cycle N into empty FIFO with FSM IDLE -> tx_valid=1 with 'K' at N+2.
//   With tx_ready held high, one report takes 4 cycles in SEND plus 1 IDLE cycle
//   (5-cycle spacing between consecutive reports).
// - Ordering strictly FIFO; reports are never interleaved or reordered.
// - Pointers wrap modulo FIFO_DEPTH; element count 0..FIFO_DEPTH resolves full vs empty.
// - busy = (state==SEND) || (FIFO count != 0), registered-equivalent, no glitches at edges.
// TESTING
// 1 Reset: key_rst low 3 cycles with key_value=0010 -> no push; all outputs 0; evt_cnt=0.
// 2 Single: S3 pulse, tx_ready=1 -> at N+2..N+5 bytes 4B,33,0D,0A; evt_cnt=1.
// 3 Back-pressure: S1, tx_ready low 10 cycles on byte 1 -> tx_data stays 8'h31, valid held;
//   resume -> 0D,0A follow.
// 4 Overflow: tx_ready=0, 6 events S1,S2,S3,S4,S1,S2 in consecutive cycles (depth 4)
//   -> first popped, 4 queued, 6th dropped (evt_drop=1); evt_cnt=5; reports K1,K2,K3,K4,K1.
// 5 Illegal codes: key_value 0000, 0011, 1111 each 1 cycle -> no push, no evt_drop,
//   tx_valid stays 0.
// 6 Mid-report reset: reset asserted after byte 'K' accepted -> tx_valid=0, FIFO empty,
//   busy=0; next S4 yields complete "K4\r\n".

Source files
------------

// File: rtl/key_event_tx.sv
// Generic synchronous FIFO with an occupancy counter that separates full from empty.
// Latency: a pushed entry is visible on pop_dat the cycle after the push edge.
// Backpressure: push_rdy is low while full, and pop only happens when pop_vld && pop_rdy.
module sync_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             push_vld,
    input  logic [WIDTH-1:0] push_dat,
    output logic             push_rdy,
    output logic             pop_vld,
    output logic [WIDTH-1:0] pop_dat,
    input  logic             pop_rdy
);
    localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CW = AW + 1;

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [WIDTH-1:0] mem_d [DEPTH];
    logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
    logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic             do_push, do_pop;

    assign push_rdy = (cnt_q != CW'(DEPTH));
    assign pop_vld  = (cnt_q != '0);
    assign pop_dat  = mem_q[rd_ptr_q];
    assign do_push  = push_vld && push_rdy;
    assign do_pop   = pop_vld && pop_rdy;

    always_comb begin
        mem_d    = mem_q;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        cnt_d    = cnt_q;
        if (do_push) begin
            mem_d[wr_ptr_q] = push_dat;
            wr_ptr_d        = wr_ptr_q + AW'(1);
        end
        if (do_pop) begin
            rd_ptr_d = rd_ptr_q + AW'(1);
        end
        case ({do_push, do_pop})
            2'b10:   cnt_d = cnt_q + CW'(1);
            2'b01:   cnt_d = cnt_q - CW'(1);
            default: cnt_d = cnt_q;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem_q[i] <= '0;
            end
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            cnt_q    <= '0;
        end else begin
            mem_q    <= mem_d;
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            cnt_q    <= cnt_d;
        end
    end
endmodule

// Turns one-hot key event pulses into queued 4-byte "K<n>\r\n" reports for a UART TX.
// Latency: event at cycle N into an empty, idle block gives tx_valid with 'K' at N+2.
// Backpressure: tx_data/tx_valid hold while !tx_ready; events arriving with the queue full are dropped.
module key_event_tx #(
    parameter int         FIFO_DEPTH = 4,
    parameter logic [7:0] PREFIX     = 8'h4B
) (
    input  logic       key_clk,
    input  logic       key_rst,
    input  logic [3:0] key_value,
    input  logic       tx_ready,
    output logic [7:0] tx_data,
    output logic       tx_valid,
    output logic       busy,
    output logic       evt_drop,
    output logic [7:0] evt_cnt
);
    typedef enum logic {
        IDLE = 1'b0,
        SEND = 1'b1
    } state_t;

    state_t     state_q, state_d;
    logic [1:0] idx_q, idx_d;
    logic [1:0] byte_idx_q, byte_idx_d;
    logic [7:0] tx_data_q, tx_data_d;
    logic       tx_valid_q, tx_valid_d;
    logic       evt_drop_q, evt_drop_d;
    logic [7:0] evt_cnt_q, evt_cnt_d;

    logic       evt_vld;
    logic [1:0] evt_idx;
    logic       fifo_rdy, fifo_vld, fifo_pop;
    logic [1:0] fifo_dat;

    function automatic logic [7:0] report_byte(input logic [1:0] sel, input logic [1:0] idx);
        case (sel)
            2'd0:    return PREFIX;
            2'd1:    return 8'h31 + {6'd0, idx};
            2'd2:    return 8'h0D;
            default: return 8'h0A;
        endcase
    endfunction

    always_comb begin
        evt_vld = 1'b1;
        evt_idx = 2'd0;
        case (key_value)
            4'b0001: evt_idx = 2'd0;
            4'b0010: evt_idx = 2'd1;
            4'b0100: evt_idx = 2'd2;
            4'b1000: evt_idx = 2'd3;
            default: evt_vld = 1'b0;
        endcase
    end

    // push_rdy reflects occupancy before this edge's pop, so a full queue drops even when popping
    sync_fifo #(
        .WIDTH (2),
        .DEPTH (FIFO_DEPTH)
    ) u_evt_fifo (
        .clk      (key_clk),
        .rst_n    (key_rst),
        .push_vld (evt_vld),
        .push_dat (evt_idx),
        .push_rdy (fifo_rdy),
        .pop_vld  (fifo_vld),
        .pop_dat  (fifo_dat),
        .pop_rdy  (fifo_pop)
    );

    always_comb begin
        state_d    = state_q;
        idx_d      = idx_q;
        byte_idx_d = byte_idx_q;
        tx_data_d  = tx_data_q;
        tx_valid_d = tx_valid_q;
        fifo_pop   = 1'b0;
        evt_drop_d = evt_vld && !fifo_rdy;
        evt_cnt_d  = (evt_vld && fifo_rdy) ? evt_cnt_q + 8'd1 : evt_cnt_q;
        case (state_q)
            IDLE: begin
                if (fifo_vld) begin
                    fifo_pop   = 1'b1;
                    idx_d      = fifo_dat;
                    byte_idx_d = 2'd0;
                    tx_data_d  = PREFIX;
                    tx_valid_d = 1'b1;
                    state_d    = SEND;
                end
            end
            SEND: begin
                if (tx_valid_q && tx_ready) begin
                    if (byte_idx_q == 2'd3) begin
                        tx_valid_d = 1'b0;
                        tx_data_d  = 8'h00;
                        state_d    = IDLE;
                    end else begin
                        byte_idx_d = byte_idx_q + 2'd1;
                        tx_data_d  = report_byte(byte_idx_q + 2'd1, idx_q);
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge key_clk) begin
        if (!key_rst) begin
            state_q    <= IDLE;
            idx_q      <= 2'd0;
            byte_idx_q <= 2'd0;
            tx_data_q  <= 8'h00;
            tx_valid_q <= 1'b0;
            evt_drop_q <= 1'b0;
            evt_cnt_q  <= 8'h00;
        end else begin
            state_q    <= state_d;
            idx_q      <= idx_d;
            byte_idx_q <= byte_idx_d;
            tx_data_q  <= tx_data_d;
            tx_valid_q <= tx_valid_d;
            evt_drop_q <= evt_drop_d;
            evt_cnt_q  <= evt_cnt_d;
        end
    end

    assign tx_data  = tx_data_q;
    assign tx_valid = tx_valid_q;
    assign evt_drop = evt_drop_q;
    assign evt_cnt  = evt_cnt_q;
    assign busy     = (state_q == SEND) || fifo_vld;
endmodule
